// File: rtl/fixed_point_pkg.sv
// Signed Q8.8 fixed-point type shared by the perceptron core and its driver.
package FixedPoint;
   typedef logic signed [15:0] sfp;
   localparam sfp ONE = 16'sh0100;
endpackage

// File: rtl/perceptron_epoch_sequencer_pkg.sv
// Sequencer state encoding for the perceptron epoch driver.
package PerceptronSeqPkg;
   typedef enum logic [1:0] {IDLE, TRAIN, EVAL, DRAIN} seq_state_e;
endpackage

// File: rtl/perceptron_sample_store.sv
// Labelled dataset register file: one write port, combinational read.
module perceptron_sample_store
   import FixedPoint::*;
#(
   parameter int INPUT_UNITS = 2,
   parameter int NUM_SAMPLES = 4,
   localparam int AW = $clog2(NUM_SAMPLES)
) (
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [AW-1:0]           wr_addr,
   input  sfp   [INPUT_UNITS-1:0]  wr_values,
   input  sfp                      wr_expected,
   input  logic [AW-1:0]           rd_addr,
   output sfp   [INPUT_UNITS-1:0]  rd_values,
   output sfp                      rd_expected
);
   sfp [INPUT_UNITS-1:0] mem_values   [NUM_SAMPLES];
   sfp                   mem_expected [NUM_SAMPLES];

   // No reset: dataset contents survive a sequencer reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_values[wr_addr]   <= wr_values;
         mem_expected[wr_addr] <= wr_expected;
      end
   end

   assign rd_values   = mem_values[rd_addr];
   assign rd_expected = mem_expected[rd_addr];
endmodule

// File: rtl/perceptron_epoch_sequencer.sv
// Runs train/eval epochs over a stored dataset against a perceptron core,
// scoring evaluation predictions until perfect accuracy or the epoch budget.
module perceptron_epoch_sequencer
   import FixedPoint::*;
   import PerceptronSeqPkg::*;
#(
   parameter int INPUT_UNITS = 2,
   parameter int NUM_SAMPLES = 4,
   parameter int MAX_EPOCHS  = 10,
   localparam int AW = $clog2(NUM_SAMPLES),
   localparam int EW = $clog2(MAX_EPOCHS + 1),
   localparam int CW = $clog2(NUM_SAMPLES + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  sfp                      lr_in,
   input  logic                    wr_en,
   input  logic [AW-1:0]           wr_addr,
   input  sfp   [INPUT_UNITS-1:0]  wr_values,
   input  sfp                      wr_expected,
   input  sfp                      prediction,
   output sfp   [INPUT_UNITS-1:0]  values,
   output sfp                      expected,
   output logic                    training,
   output sfp                      learning_rate,
   output logic                    busy,
   output logic                    done,
   output logic                    converged,
   output logic [EW-1:0]           epoch_count,
   output logic [CW-1:0]           correct_count
);
   localparam logic [AW-1:0] LAST_IDX    = AW'(NUM_SAMPLES - 1);
   localparam logic [EW-1:0] EPOCH_LIMIT = EW'(MAX_EPOCHS);
   localparam logic [CW-1:0] FULL_SCORE  = CW'(NUM_SAMPLES);

   seq_state_e               state;
   logic [AW-1:0]            idx;
   logic [AW-1:0]            rd_addr;
   logic [CW-1:0]            score;
   logic [CW-1:0]            final_score;
   logic [EW-1:0]            next_epoch;
   sfp                       exp_d;
   logic                     eval_d;
   logic                     hit;
   logic                     store_wr;
   sfp [INPUT_UNITS-1:0]     rd_values;
   sfp                       rd_expected;
   sfp [INPUT_UNITS-1:0]     first_values;
   sfp                       first_expected;

   assign store_wr = rst && wr_en && (state == IDLE);

   perceptron_sample_store #(
      .INPUT_UNITS (INPUT_UNITS),
      .NUM_SAMPLES (NUM_SAMPLES)
   ) u_store (
      .clk         (clk),
      .wr_en       (store_wr),
      .wr_addr     (wr_addr),
      .wr_values   (wr_values),
      .wr_expected (wr_expected),
      .rd_addr     (rd_addr),
      .rd_values   (rd_values),
      .rd_expected (rd_expected)
   );

   // Read port looks one sample ahead so presentations are registered.
   always_comb begin
      rd_addr = '0;
      if ((state == TRAIN || state == EVAL) && idx != LAST_IDX)
         rd_addr = idx + 1'b1;
   end

   // A write to slot 0 in the start cycle must reach the first presentation.
   always_comb begin
      first_values   = rd_values;
      first_expected = rd_expected;
      if (store_wr && wr_addr == '0) begin
         first_values   = wr_values;
         first_expected = wr_expected;
      end
   end

   // prediction answers the presentation made two edges ago; exp_d/eval_d track it.
   assign hit         = eval_d && (prediction == exp_d);
   assign final_score = score + CW'(hit);
   assign next_epoch  = epoch_count + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         idx           <= '0;
         score         <= '0;
         exp_d         <= '0;
         eval_d        <= 1'b0;
         values        <= '0;
         expected      <= '0;
         training      <= 1'b0;
         learning_rate <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         converged     <= 1'b0;
         epoch_count   <= '0;
         correct_count <= '0;
      end else begin
         done   <= 1'b0;
         exp_d  <= expected;
         eval_d <= (state == EVAL);
         score  <= final_score;
         case (state)
            IDLE: begin
               if (start) begin
                  learning_rate <= lr_in;
                  epoch_count   <= '0;
                  correct_count <= '0;
                  converged     <= 1'b0;
                  busy          <= 1'b1;
                  idx           <= '0;
                  values        <= first_values;
                  expected      <= first_expected;
                  training      <= 1'b1;
                  state         <= TRAIN;
               end
            end
            TRAIN: begin
               values   <= rd_values;
               expected <= rd_expected;
               if (idx == LAST_IDX) begin
                  idx      <= '0;
                  training <= 1'b0;
                  score    <= '0;
                  state    <= EVAL;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            EVAL: begin
               if (idx == LAST_IDX) begin
                  values   <= '0;
                  expected <= '0;
                  state    <= DRAIN;
               end else begin
                  idx      <= idx + 1'b1;
                  values   <= rd_values;
                  expected <= rd_expected;
               end
            end
            DRAIN: begin
               correct_count <= final_score;
               epoch_count   <= next_epoch;
               if (final_score == FULL_SCORE || next_epoch == EPOCH_LIMIT) begin
                  converged <= (final_score == FULL_SCORE);
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  idx      <= '0;
                  values   <= rd_values;
                  expected <= rd_expected;
                  training <= 1'b1;
                  state    <= TRAIN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_perceptron_epoch_sequencer.sv
// Directed and randomized checks of the epoch sequencer against a dataset-level model.
module tb_perceptron_epoch_sequencer;
   import FixedPoint::*;

   localparam int NI = 2, NS = 4, ME = 10, EP_LEN = 2*NS + 1;

   logic           clk = 1'b0, rst = 1'b0, start = 1'b0, wr_en = 1'b0;
   sfp             lr_in = '0, wr_expected = '0, prediction;
   logic [1:0]     wr_addr = '0;
   sfp [NI-1:0]    wr_values = '0;
   sfp [NI-1:0]    values;
   sfp             expected, learning_rate;
   logic           training, busy, done, converged;
   logic [3:0]     epoch_count;
   logic [2:0]     correct_count;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   perceptron_epoch_sequencer #(.INPUT_UNITS(NI), .NUM_SAMPLES(NS), .MAX_EPOCHS(ME)) dut (
      .clk(clk), .rst(rst), .start(start), .lr_in(lr_in), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_values(wr_values), .wr_expected(wr_expected), .prediction(prediction),
      .values(values), .expected(expected), .training(training), .learning_rate(learning_rate),
      .busy(busy), .done(done), .converged(converged), .epoch_count(epoch_count),
      .correct_count(correct_count)
   );

   // Reference dataset as the bench believes it is stored.
   sfp ds_val [NS][NI];
   sfp ds_exp [NS];

   // Prediction sources: 0 echo label, 1 constant zero, 2 sign of input 0, 3 perceptron model.
   int   mode = 0;
   sfp   stub_pred, core_pred, core_out;
   logic core_clr = 1'b1;
   int   w0, w1, b, acc, d;

   assign prediction = (mode == 3) ? core_pred : stub_pred;

   always @(posedge clk) begin
      case (mode)
         0:       stub_pred <= expected;
         1:       stub_pred <= '0;
         default: stub_pred <= ($signed(values[0]) > 16'sd0) ? ONE : '0;
      endcase
   end

   always_comb begin
      acc      = b + ((w0 * int'(values[0])) >>> 8) + ((w1 * int'(values[1])) >>> 8);
      core_out = (acc > 0) ? ONE : '0;
      d        = (int'(learning_rate) * (int'(expected) - int'(core_out))) >>> 8;
   end

   always @(posedge clk) begin
      if (core_clr) begin
         w0 <= 0; w1 <= 0; b <= 0; core_pred <= '0;
      end else begin
         core_pred <= core_out;
         if (training) begin
            w0 <= w0 + ((d * int'(values[0])) >>> 8);
            w1 <= w1 + ((d * int'(values[1])) >>> 8);
            b  <= b + d;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic sfp model_pred(input int m, input int s);
      case (m)
         0:       return ds_exp[s];
         1:       return '0;
         default: return ($signed(ds_val[s][0]) > 16'sd0) ? ONE : '0;
      endcase
   endfunction

   function automatic int model_score(input int m);
      int sc = 0;
      for (int s = 0; s < NS; s++) if (model_pred(m, s) == ds_exp[s]) sc++;
      return sc;
   endfunction

   task automatic write_slot(input int a, input sfp v0, input sfp v1, input sfp e);
      wr_en = 1'b1; wr_addr = 2'(a); wr_values[0] = v0; wr_values[1] = v1; wr_expected = e;
      @(negedge clk);
      wr_en = 1'b0;
      ds_val[a][0] = v0; ds_val[a][1] = v1; ds_exp[a] = e;
   endtask

   task automatic load_and();
      write_slot(0, '0, '0, '0);
      write_slot(1, '0, ONE, '0);
      write_slot(2, ONE, '0, '0);
      write_slot(3, ONE, ONE, ONE);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_values"}, values, '0);
      chk({tag, "_expected"}, expected, '0);
      chk({tag, "_training"}, training, 0);
      chk({tag, "_lr"}, learning_rate, '0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_converged"}, converged, 0);
      chk({tag, "_epoch"}, epoch_count, 0);
      chk({tag, "_correct"}, correct_count, 0);
   endtask

   // Full run with a known epoch count; optionally checks every presentation
   // and injects a start pulse plus slot-0 write mid-run.
   task automatic run_and_check(input string tag, input sfp lr, input int m, input logic trace,
                                input logic inject);
      int sc, ep;
      sfp [NI-1:0] ev;
      sfp ee;
      logic et;
      sc = model_score(m);
      ep = (sc == NS) ? 1 : ME;
      mode = m;
      start = 1'b1; lr_in = lr;
      @(negedge clk);
      start = 1'b0; lr_in = sfp'($urandom_range(0, 65535));
      for (int c = 1; c <= EP_LEN*ep; c++) begin
         int pos = (c - 1) % EP_LEN;
         ev = '0; ee = '0; et = 1'b0;
         if (pos < 2*NS) begin
            for (int i = 0; i < NI; i++) ev[i] = ds_val[pos % NS][i];
            ee = ds_exp[pos % NS];
            et = (pos < NS);
         end
         if (trace) begin
            chk({tag, "_values"}, ev === values ? 1 : 0, 1);
            chk({tag, "_expected"}, expected, ee);
            chk({tag, "_training"}, training, et);
         end
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_done_early"}, done, 0);
         if (inject && c == 5) begin
            start = 1'b1; wr_en = 1'b1; wr_addr = 2'd0;
            wr_values[0] = ONE; wr_values[1] = ONE; wr_expected = ONE;
         end else begin
            start = 1'b0; wr_en = 1'b0;
         end
         @(negedge clk);
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_converged"}, converged, (sc == NS));
      chk({tag, "_epoch"}, epoch_count, ep);
      chk({tag, "_correct"}, correct_count, sc);
      chk({tag, "_lr"}, learning_rate, lr);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_converged_hold"}, converged, (sc == NS));
   endtask

   initial begin
      // power-on reset
      repeat (2) @(negedge clk);
      chk_cleared("por");
      rst = 1'b1;
      @(negedge clk);
      load_and();

      // reset held with start and a slot-0 write must do nothing
      rst = 1'b0; start = 1'b1; wr_en = 1'b1; wr_addr = 2'd0;
      wr_values[0] = ONE; wr_values[1] = ONE; wr_expected = ONE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_cleared("rst_hold");
      end
      rst = 1'b1; start = 1'b0; wr_en = 1'b0;
      @(negedge clk);

      // AND table, label echo: converges in one epoch; trace proves slot 0 intact
      run_and_check("and_echo", ONE, 0, 1'b1, 1'b0);

      // AND table, prediction stuck at 0: full budget at 3/4
      run_and_check("and_zero", ONE, 1, 1'b0, 1'b0);

      // reset during the third TRAIN presentation
      mode = 0;
      start = 1'b1; lr_in = ONE;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_pre_training", training, 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk_cleared("mid_rst");
      run_and_check("after_rst", ONE, 0, 1'b1, 1'b0);

      // start and write while busy are ignored
      run_and_check("busy_inject", 16'sh0080, 0, 1'b1, 1'b1);
      write_slot(0, ONE, ONE, ONE);
      run_and_check("idle_write", 16'sh0040, 0, 1'b1, 1'b0);

      // randomized datasets and prediction sources
      for (int r = 0; r < 4; r++) begin
         for (int s = 0; s < NS; s++)
            write_slot(s, sfp'($urandom_range(0, 65535)), sfp'($urandom_range(0, 65535)),
                       $urandom_range(0, 1) ? ONE : '0);
         run_and_check($sformatf("rand%0d", r), sfp'($urandom_range(0, 65535)),
                       int'($urandom_range(0, 2)), 1'b1, 1'b0);
      end

      // AND table against a perceptron model
      load_and();
      mode = 3; core_clr = 1'b1;
      @(negedge clk);
      core_clr = 1'b0;
      for (int run = 0; run < 2; run++) begin
         int cyc = 0;
         start = 1'b1; lr_in = ONE;
         @(negedge clk);
         start = 1'b0;
         while (!done && cyc < EP_LEN*ME + 10) begin
            @(negedge clk);
            cyc++;
         end
         chk($sformatf("core%0d_done", run), done, 1);
         chk($sformatf("core%0d_converged", run), converged, 1);
         chk($sformatf("core%0d_correct", run), correct_count, NS);
         if (run == 0)
            chk("core0_epoch_in_budget", (epoch_count >= 1 && epoch_count <= ME) ? 1 : 0, 1);
         else
            chk("core1_epoch", epoch_count, 1);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
